// File: rtl/md_pkg.sv
// Shared op codes, FSM state type and op-class helpers for the multiply/divide unit.
package md_pkg;

   localparam logic [3:0] MULT  = 4'd0;
   localparam logic [3:0] MULTU = 4'd1;
   localparam logic [3:0] DIV   = 4'd2;
   localparam logic [3:0] DIVU  = 4'd3;
   localparam logic [3:0] MADD  = 4'd4;
   localparam logic [3:0] MADDU = 4'd5;
   localparam logic [3:0] MSUB  = 4'd6;
   localparam logic [3:0] MSUBU = 4'd7;
   localparam logic [3:0] MTHI  = 4'd8;
   localparam logic [3:0] MTLO  = 4'd9;

   typedef enum logic [0:0] {StIdle, StRun} md_state_e;

   // Long ops occupy the unit for a full latency; codes 0..7 are all long.
   function automatic logic is_long_op(input logic [3:0] op);
      return op <= MSUBU;
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == DIV) || (op == DIVU);
   endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational result datapath: produces the next {hi,lo} for any op code, including
// the divide-by-zero and signed-overflow conventions.
module md_compute
   import md_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [3:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [2*WIDTH-1:0] hilo,
   output logic [2*WIDTH-1:0] result
);

   localparam int unsigned W2 = 2 * WIDTH;

   logic [W2-1:0]    a_s, b_s, a_u, b_u;
   logic [W2-1:0]    prod_s, prod_u;
   logic             div_signed, a_neg, b_neg;
   logic [WIDTH-1:0] num, den, uq, ur, q, r;
   logic [WIDTH-1:0] int_min, all_ones;

   // Sign-extended operands multiplied modulo 2^W2 give the exact signed product.
   assign a_s    = {{WIDTH{a[WIDTH-1]}}, a};
   assign b_s    = {{WIDTH{b[WIDTH-1]}}, b};
   assign a_u    = {{WIDTH{1'b0}}, a};
   assign b_u    = {{WIDTH{1'b0}}, b};
   assign prod_s = a_s * b_s;
   assign prod_u = a_u * b_u;

   assign int_min  = {1'b1, {(WIDTH-1){1'b0}}};
   assign all_ones = {WIDTH{1'b1}};

   always_comb begin
      div_signed = (op == DIV);
      a_neg      = div_signed && a[WIDTH-1];
      b_neg      = div_signed && b[WIDTH-1];
      num        = a_neg ? -a : a;
      den        = b_neg ? -b : b;
      uq         = '0;
      ur         = '0;
      if (den != '0) begin
         uq = num / den;
         ur = num % den;
      end
      q = (a_neg ^ b_neg) ? -uq : uq;
      r = a_neg ? -ur : ur;
   end

   always_comb begin
      result = hilo;
      case (op)
         MULT:  result = prod_s;
         MULTU: result = prod_u;
         DIV, DIVU: begin
            if (b == '0) begin
               result = {a, all_ones};
            end else if (div_signed && (a == int_min) && (b == all_ones)) begin
               result = {{WIDTH{1'b0}}, int_min};
            end else begin
               result = {r, q};
            end
         end
         MADD:  result = hilo + prod_s;
         MADDU: result = hilo + prod_u;
         MSUB:  result = hilo - prod_s;
         MSUBU: result = hilo - prod_u;
         MTHI:  result = {a, hilo[WIDTH-1:0]};
         MTLO:  result = {hilo[W2-1:WIDTH], a};
         default: result = hilo;
      endcase
   end

endmodule

// File: rtl/md_unit_param.sv
// Multiply/divide unit owning HI/LO: results are computed at accept into a shadow
// register and committed after a fixed per-op latency, unless flushed.
module md_unit_param
   import md_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned MUL_LAT = 5,
   parameter int unsigned DIV_LAT = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   md_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   shadow_q;
   logic [WIDTH-1:0]     hi_q, lo_q;
   logic                 done_q;
   logic [2*WIDTH-1:0]   result;
   logic                 accept, mt_write, commit;

   md_compute #(
      .WIDTH(WIDTH)
   ) u_compute (
      .op    (op),
      .a     (a),
      .b     (b),
      .hilo  ({hi_q, lo_q}),
      .result(result)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StRun;
               cnt_d   = is_div(op) ? DIV_CNT : MUL_CNT;
            end
         end
         StRun: begin
            if (flush || (cnt_q == CNT_ONE)) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // Output / control decode; a flush always beats both start and commit.
   always_comb begin
      accept   = (state_q == StIdle) && start && !flush && is_long_op(op);
      mt_write = (state_q == StIdle) && start && !flush && ((op == MTHI) || (op == MTLO));
      commit   = (state_q == StRun) && !flush && (cnt_q == CNT_ONE);
      busy     = (state_q == StRun);
      done     = done_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= commit;
         if (accept) begin
            shadow_q <= result;
         end
         if (commit) begin
            {hi_q, lo_q} <= shadow_q;
         end else if (mt_write) begin
            {hi_q, lo_q} <= result;
         end
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: tb/tb_md_unit_param.sv
// Scoreboard bench for md_unit_param: expected {hi,lo} commits are queued at issue and
// checked by a monitor on each done pulse; timing, flush and reset are checked inline.
module tb_md_unit_param;
   import md_pkg::*;

   localparam int unsigned WIDTH   = 32;
   localparam int unsigned MUL_LAT = 5;
   localparam int unsigned DIV_LAT = 10;

   logic             clk, reset, start, flush, busy, done;
   logic [3:0]       op;
   logic [WIDTH-1:0] a, b, hi, lo;

   int unsigned passed = 0;
   int unsigned total  = 0;
   int unsigned done_seen = 0;
   int unsigned n_expected = 0;
   logic [63:0] exp_q[$];

   md_unit_param #(
      .WIDTH  (WIDTH),
      .MUL_LAT(MUL_LAT),
      .DIV_LAT(DIV_LAT)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .start(start),
      .op   (op),
      .a    (a),
      .b    (b),
      .flush(flush),
      .busy (busy),
      .done (done),
      .hi   (hi),
      .lo   (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%016h, required 0x%016h", name, act, exp);
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (reset && done) begin
         done_seen++;
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL spurious_done: got done with hi/lo 0x%08h_%08h, required no done",
                     hi, lo);
         end else begin
            check("commit_hilo", {hi, lo}, exp_q.pop_front());
         end
      end
   end

   task automatic expect_commit(input logic [63:0] v);
      exp_q.push_back(v);
      n_expected++;
   endtask

   task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts cycles busy stays high from now; bounded so a stuck busy still fails.
   task automatic expect_busy(input string name, input int lat);
      int n = 0;
      while (busy && n < lat + 20) begin
         n++;
         @(posedge clk);
         #1;
      end
      check(name, n, lat);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required $finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      op    = 4'd0;
      a     = '0;
      b     = '0;
      #12;
      check("reset_hilo", {hi, lo}, 64'h0);
      check("reset_busy_done", {62'h0, busy, done}, 64'h0);
      @(negedge clk);
      reset = 1'b1;

      expect_commit(64'hFFFFFFFF_FFFFFFEB);
      issue(MULT, 32'hFFFFFFFD, 32'd7);
      expect_busy("mult_busy_cycles", MUL_LAT);
      check("mult_done_now", {63'h0, done}, 64'h1);

      // Issued in the done cycle of the previous op.
      expect_commit(64'h00000002_0000000E);
      issue(DIVU, 32'd100, 32'd7);
      expect_busy("divu_busy_cycles", DIV_LAT);

      expect_commit(64'hFFFFFFFF_FFFFFFFD);
      issue(DIV, 32'hFFFFFFF9, 32'd2);
      expect_busy("div_busy_cycles", DIV_LAT);

      expect_commit(64'h00000005_FFFFFFFF);
      issue(DIV, 32'd5, 32'd0);
      expect_busy("div0_busy_cycles", DIV_LAT);

      expect_commit(64'h00000000_80000000);
      issue(DIV, 32'h80000000, 32'hFFFFFFFF);
      expect_busy("divovf_busy_cycles", DIV_LAT);

      issue(MTHI, 32'd1, 32'd0);
      check("mthi_hilo", {hi, lo}, 64'h00000001_80000000);
      check("mthi_busy_done", {62'h0, busy, done}, 64'h0);
      issue(MTLO, 32'hFFFFFFFF, 32'd0);
      check("mtlo_hilo", {hi, lo}, 64'h00000001_FFFFFFFF);

      expect_commit(64'h00000002_00000000);
      issue(MADDU, 32'd1, 32'd1);
      expect_busy("maddu_busy_cycles", MUL_LAT);

      expect_commit(64'h00000001_FFFFFFFF);
      issue(MSUB, 32'd1, 32'd1);
      expect_busy("msub_busy_cycles", MUL_LAT);

      expect_commit(64'h00000001_FFFFFFFD);
      issue(MADD, 32'hFFFFFFFF, 32'd2);
      expect_busy("madd_busy_cycles", MUL_LAT);

      expect_commit(64'hFFFFFFFF_FFFFFFFF);
      issue(MSUBU, 32'hFFFFFFFF, 32'd2);
      expect_busy("msubu_busy_cycles", MUL_LAT);

      // Flush in the third RUN cycle.
      issue(MULT, 32'd2, 32'd3);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_busy", {63'h0, busy}, 64'h0);
      check("flush_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
      repeat (8) @(posedge clk);
      #1;
      check("flush_no_done", done_seen, n_expected);

      // Flush and start together: MTLO must be dropped.
      @(negedge clk);
      start = 1'b1;
      flush = 1'b1;
      op    = MTLO;
      a     = 32'h00001234;
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      check("flush_start_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
      check("flush_start_busy", {63'h0, busy}, 64'h0);

      // Starts while busy are ignored, MT* included.
      expect_commit(64'h00000000_00000014);
      issue(MULTU, 32'd4, 32'd5);
      @(posedge clk);
      #1;
      issue(MTHI, 32'hDEADBEEF, 32'd0);
      issue(DIVU, 32'd9, 32'd3);
      expect_busy("busy_ignore_cycles", 2);

      expect_commit(64'h00000000_0000002A);
      issue(MULTU, 32'd6, 32'd7);
      expect_busy("b2b_busy_cycles", MUL_LAT);
      @(posedge clk);
      #1;

      // Asynchronous reset mid-op.
      issue(DIVU, 32'd50, 32'd5);
      repeat (3) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("async_reset_hilo", {hi, lo}, 64'h0);
      check("async_reset_busy", {62'h0, busy, done}, 64'h0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_idle", {63'h0, busy}, 64'h0);
      issue(MTLO, 32'd7, 32'd0);
      check("post_reset_mtlo", {hi, lo}, 64'h00000000_00000007);
      repeat (14) @(posedge clk);
      #1;
      check("total_done_pulses", done_seen, n_expected);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
